ma_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. It owns the EX/MA pipeline latch and the word-addressed data memory. It also produces the MA/RW pipeline register consumed by register write-back, and drives the MA-stage ALU result back to execute for forwarding. Loads and stores take a configurable number of wait cycles, during which the stage stalls upstream and emits bubbles downstream.

---
 rtl/ma_stage.sv | 153 +++++++++++++++
 tb/tb_ma_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ma_stage.sv
// ---------------------------------------------------------------------------
// ma_stage -- memory-access stage of the five-stage pipeline.
//
// Sits directly downstream of execute. Owns the EX/MA pipeline latch, the
// word-addressed data memory and the MA/RW pipeline register that feeds
// register write-back. Loads and stores spend MEM_LATENCY extra cycles
// waiting; while waiting the stage stalls upstream and sends bubbles
// downstream.
//
// Parameters
//   MEM_LATENCY  extra wait cycles per load/store (0..15)
//   DEPTH        data memory depth in 32-bit words (power of two)
//
// Ports
//   clk                 in   rising-edge clock
//   rst                 in   asynchronous, active-low reset
//   pc_to_ma            in   PC from execute
//   aluResult           in   ALU result from execute / load-store byte address
//   op2                 in   store data from execute
//   inst_out_ex         in   instruction from execute
//   control_signals_ex  in   control vector (bit0 isSt, bit1 isLd, bit6 isWb,
//                            bit8 isCall)
//   stall_ma            out  high while a memory op is waiting
//   ALUres_from_bahar   out  latched ALU result, forwarded back to execute
//   pc_out_ma           out  MA/RW register: PC
//   aluResult_ma        out  MA/RW register: ALU result
//   ldResult            out  MA/RW register: load data (0 for non-loads)
//   inst_out_ma         out  MA/RW register: instruction
//   control_signals_ma  out  MA/RW register: control vector
// ---------------------------------------------------------------------------
module ma_stage #(
    parameter int MEM_LATENCY = 1,
    parameter int DEPTH       = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_to_ma,
    input  logic [31:0] aluResult,
    input  logic [31:0] op2,
    input  logic [31:0] inst_out_ex,
    input  logic [21:0] control_signals_ex,
    output logic        stall_ma,
    output logic [31:0] ALUres_from_bahar,
    output logic [31:0] pc_out_ma,
    output logic [31:0] aluResult_ma,
    output logic [31:0] ldResult,
    output logic [31:0] inst_out_ma,
    output logic [21:0] control_signals_ma
);

    localparam int AW = $clog2(DEPTH);

    localparam int CTRL_IS_ST = 0;
    localparam int CTRL_IS_LD = 1;

    // IDLE means no memory op is outstanding; WAIT means the op in the
    // latch is still counting down its wait cycles.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // EX/MA latch contents
    logic [31:0] ex_pc;
    logic [31:0] ex_alu;
    logic [31:0] ex_op2;
    logic [31:0] ex_inst;
    logic [21:0] ex_ctrl;

    // Remaining wait cycles for the op held in the latch
    logic [3:0]  cnt;
    state_t      state;

    // Data memory and its port signals
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic          in_is_mem;

    // The state is a pure decode of the counter, so stall_ma comes straight
    // from a register with no dependence on the incoming instruction.
    assign state    = (cnt != 4'd0) ? WAIT : IDLE;
    assign stall_ma = (state == WAIT);

    // Word address from the latched byte address; the byte offset and any
    // bits above the memory size are dropped, so addresses wrap.
    assign mem_addr  = ex_alu[AW+1:2];
    assign mem_rdata = mem[mem_addr];

    assign in_is_mem = control_signals_ex[CTRL_IS_ST] | control_signals_ex[CTRL_IS_LD];

    assign ALUres_from_bahar = ex_alu;

    // Pipeline control: the latch, the wait counter and the MA/RW register
    // all advance together. In IDLE the op in the latch retires into MA/RW
    // and the next op from execute is captured; a newly captured memory op
    // arms the counter. In WAIT everything in the latch is frozen, the
    // counter runs down and MA/RW receives bubbles until the op completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_pc              <= '0;
            ex_alu             <= '0;
            ex_op2             <= '0;
            ex_inst            <= '0;
            ex_ctrl            <= '0;
            cnt                <= '0;
            pc_out_ma          <= '0;
            aluResult_ma       <= '0;
            ldResult           <= '0;
            inst_out_ma        <= '0;
            control_signals_ma <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pc_out_ma          <= ex_pc;
                    aluResult_ma       <= ex_alu;
                    ldResult           <= ex_ctrl[CTRL_IS_LD] ? mem_rdata : 32'd0;
                    inst_out_ma        <= ex_inst;
                    control_signals_ma <= ex_ctrl;

                    ex_pc   <= pc_to_ma;
                    ex_alu  <= aluResult;
                    ex_op2  <= op2;
                    ex_inst <= inst_out_ex;
                    ex_ctrl <= control_signals_ex;
                    cnt     <= in_is_mem ? 4'(MEM_LATENCY) : 4'd0;
                end
                WAIT: begin
                    pc_out_ma          <= '0;
                    aluResult_ma       <= '0;
                    ldResult           <= '0;
                    inst_out_ma        <= '0;
                    control_signals_ma <= '0;
                    cnt                <= cnt - 4'd1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Store write happens only on the completing edge of a store, so each
    // store writes exactly once. A reset clears the latch, which both aborts
    // a pending store and keeps memory untouched while reset is held.
    // Memory contents themselves are never cleared by reset.
    always_ff @(posedge clk) begin
        if (!stall_ma && ex_ctrl[CTRL_IS_ST]) begin
            mem[mem_addr] <= ex_op2;
        end
    end

endmodule

// File: tb/tb_ma_stage.sv
// ---------------------------------------------------------------------------
// tb_ma_stage -- directed bench for ma_stage.
//
// Two instances are used: u_l1 with MEM_LATENCY = 1 and u_l3 with
// MEM_LATENCY = 3. Each has its own input set; the idle instance is fed
// bubbles. Inputs change #1 after a rising edge and outputs are sampled
// at that same point.
// ---------------------------------------------------------------------------
module tb_ma_stage;

    localparam logic [21:0] C_ST = 22'h000001;
    localparam logic [21:0] C_LD = 22'h000002;
    localparam logic [21:0] C_WB = 22'h000040;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [31:0] pc1, alu1, op21, inst1;
    logic [21:0] ctrl1;
    logic [31:0] pc3, alu3, op23, inst3;
    logic [21:0] ctrl3;

    logic        s1_stall, s3_stall;
    logic [31:0] s1_fwd, s1_pc, s1_alu, s1_ld, s1_inst;
    logic [31:0] s3_fwd, s3_pc, s3_alu, s3_ld, s3_inst;
    logic [21:0] s1_ctrl, s3_ctrl;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ma_stage #(.MEM_LATENCY(1), .DEPTH(1024)) u_l1 (
        .clk                (clk),
        .rst                (rst),
        .pc_to_ma           (pc1),
        .aluResult          (alu1),
        .op2                (op21),
        .inst_out_ex        (inst1),
        .control_signals_ex (ctrl1),
        .stall_ma           (s1_stall),
        .ALUres_from_bahar  (s1_fwd),
        .pc_out_ma          (s1_pc),
        .aluResult_ma       (s1_alu),
        .ldResult           (s1_ld),
        .inst_out_ma        (s1_inst),
        .control_signals_ma (s1_ctrl)
    );

    ma_stage #(.MEM_LATENCY(3), .DEPTH(1024)) u_l3 (
        .clk                (clk),
        .rst                (rst),
        .pc_to_ma           (pc3),
        .aluResult          (alu3),
        .op2                (op23),
        .inst_out_ex        (inst3),
        .control_signals_ex (ctrl3),
        .stall_ma           (s3_stall),
        .ALUres_from_bahar  (s3_fwd),
        .pc_out_ma          (s3_pc),
        .aluResult_ma       (s3_alu),
        .ldResult           (s3_ld),
        .inst_out_ma        (s3_inst),
        .control_signals_ma (s3_ctrl)
    );

    // Drive one instance's execute-side inputs; sel = 1 picks u_l1,
    // anything else picks u_l3.
    task automatic applyStimulus(input int sel, input logic [31:0] pc,
                                 input logic [31:0] alu, input logic [31:0] d,
                                 input logic [31:0] inst, input logic [21:0] ctrl);
        if (sel == 1) begin
            pc1 = pc; alu1 = alu; op21 = d; inst1 = inst; ctrl1 = ctrl;
        end else begin
            pc3 = pc; alu3 = alu; op23 = d; inst3 = inst; ctrl3 = ctrl;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(3, 0, 0, 0, 0, 0);
        #1;
        // ---- reset state while rst is held low
        checkOutput("rst_init_stall1", 32'(s1_stall), 32'd0);
        checkOutput("rst_init_fwd1", s1_fwd, 32'd0);
        checkOutput("rst_init_alu1", s1_alu, 32'd0);
        ticks(2);
        rst = 1'b1;

        // ---- asynchronous reset mid-cycle with nonzero contents
        $display("[TB] async reset");
        applyStimulus(1, 32'h100, 32'h10, 32'h5, 32'h33, C_WB);
        applyStimulus(3, 32'h100, 32'h10, 32'h5, 32'h33, C_WB);
        ticks(2);
        checkOutput("pre_rst_alu_ma", s1_alu, 32'h10);
        checkOutput("pre_rst_fwd", s1_fwd, 32'h10);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_stall", 32'(s1_stall), 32'd0);
        checkOutput("rst_fwd", s1_fwd, 32'd0);
        checkOutput("rst_pc_ma", s1_pc, 32'd0);
        checkOutput("rst_alu_ma", s1_alu, 32'd0);
        checkOutput("rst_inst_ma", s1_inst, 32'd0);
        checkOutput("rst_ctrl_ma", 32'(s1_ctrl), 32'd0);
        checkOutput("rst_fwd3", s3_fwd, 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(3, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b1;

        // ---- ALU pass-through on u_l1
        $display("[TB] alu pass-through");
        applyStimulus(1, 32'h200, 32'h10, 32'h99, 32'h33, C_WB);
        tick();
        checkOutput("add_stall_n", 32'(s1_stall), 32'd0);
        checkOutput("add_fwd_n", s1_fwd, 32'h10);
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        checkOutput("add_alu_ma", s1_alu, 32'h10);
        checkOutput("add_ld_ma", s1_ld, 32'd0);
        checkOutput("add_pc_ma", s1_pc, 32'h200);
        checkOutput("add_ctrl_ma", 32'(s1_ctrl), 32'(C_WB));
        checkOutput("add_stall_n1", 32'(s1_stall), 32'd0);

        // ---- store then load on u_l1
        $display("[TB] store then load");
        applyStimulus(1, 32'h300, 32'h40, 32'hDEADBEEF, 32'h23, C_ST);
        tick();                                   // store accepted (S)
        checkOutput("st_stall_s", 32'(s1_stall), 32'd1);
        applyStimulus(1, 32'h304, 32'h40, 32'h0, 32'h03, C_LD | C_WB);
        tick();                                   // S+1: bubble
        checkOutput("st_bubble_inst", s1_inst, 32'd0);
        checkOutput("st_bubble_ctrl", 32'(s1_ctrl), 32'd0);
        checkOutput("st_stall_s1", 32'(s1_stall), 32'd0);
        tick();                                   // S+2: store retires, load accepted
        checkOutput("st_retire_inst", s1_inst, 32'h23);
        checkOutput("st_retire_ld", s1_ld, 32'd0);
        checkOutput("ld_stall_s2", 32'(s1_stall), 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();                                   // S+3: bubble between ops
        checkOutput("between_inst", s1_inst, 32'd0);
        tick();                                   // S+4: load retires
        checkOutput("ld_result", s1_ld, 32'hDEADBEEF);
        checkOutput("ld_alu_ma", s1_alu, 32'h40);
        checkOutput("ld_pc_ma", s1_pc, 32'h304);

        // ---- address wrap on u_l1
        $display("[TB] address wrap");
        applyStimulus(1, 32'h310, 32'h1000, 32'h1234, 32'h23, C_ST);
        tick();
        applyStimulus(1, 32'h314, 32'h0, 32'h0, 32'h03, C_LD | C_WB);
        ticks(2);
        applyStimulus(1, 0, 0, 0, 0, 0);
        ticks(2);
        checkOutput("wrap_ld", s1_ld, 32'h1234);
        checkOutput("wrap_pc", s1_pc, 32'h314);

        // ---- stall hold on u_l3: seed 0x80, then load it while inputs move
        $display("[TB] stall hold");
        applyStimulus(3, 32'h3F0, 32'h80, 32'hCAFEF00D, 32'h23, C_ST);
        tick();
        applyStimulus(3, 0, 0, 0, 0, 0);
        ticks(3);
        checkOutput("l3_stall_done", 32'(s3_stall), 32'd0);
        applyStimulus(3, 32'h400, 32'h80, 32'h0, 32'h03, C_LD | C_WB);
        tick();                                   // N: store retires, load accepted
        checkOutput("l3_st_retire", s3_inst, 32'h23);
        checkOutput("l3_stall_n", 32'(s3_stall), 32'd1);
        applyStimulus(3, 32'h500, 32'hFFF0, 32'h7, 32'h13, C_WB);
        tick();                                   // N+1
        checkOutput("hold_fwd_n1", s3_fwd, 32'h80);
        checkOutput("hold_bubble_n1", s3_inst, 32'd0);
        checkOutput("hold_stall_n1", 32'(s3_stall), 32'd1);
        tick();                                   // N+2
        checkOutput("hold_bubble_n2", s3_inst, 32'd0);
        checkOutput("hold_stall_n2", 32'(s3_stall), 32'd1);
        tick();                                   // N+3
        checkOutput("hold_bubble_n3", s3_ctrl, 32'd0);
        checkOutput("hold_fwd_n3", s3_fwd, 32'h80);
        checkOutput("hold_stall_n3", 32'(s3_stall), 32'd0);
        tick();                                   // N+4: load retires, new op accepted
        checkOutput("hold_ld_n4", s3_ld, 32'hCAFEF00D);
        checkOutput("hold_pc_n4", s3_pc, 32'h400);
        checkOutput("hold_fwd_n4", s3_fwd, 32'hFFF0);
        checkOutput("hold_stall_n4", 32'(s3_stall), 32'd0);
        applyStimulus(3, 0, 0, 0, 0, 0);
        tick();                                   // N+5: the add retires
        checkOutput("hold_add_alu", s3_alu, 32'hFFF0);
        checkOutput("hold_add_ld", s3_ld, 32'd0);

        // ---- reset abort on u_l3: 0xAA at 0x8, then abort a 0x55 store
        $display("[TB] reset abort");
        applyStimulus(3, 32'h600, 32'h8, 32'hAA, 32'h23, C_ST);
        tick();
        applyStimulus(3, 0, 0, 0, 0, 0);
        ticks(3);
        applyStimulus(3, 32'h604, 32'h8, 32'h55, 32'h23, C_ST);
        tick();                                   // 0xAA retires, 0x55 accepted
        applyStimulus(3, 0, 0, 0, 0, 0);
        tick();
        checkOutput("abort_stall_pre", 32'(s3_stall), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_stall", 32'(s3_stall), 32'd0);
        checkOutput("abort_fwd", s3_fwd, 32'd0);
        #1;
        rst = 1'b1;
        applyStimulus(3, 32'h608, 32'h8, 32'h0, 32'h03, C_LD | C_WB);
        tick();
        applyStimulus(3, 0, 0, 0, 0, 0);
        ticks(3);
        checkOutput("abort_bubble", s3_inst, 32'd0);
        tick();
        checkOutput("abort_ld", s3_ld, 32'hAA);
        checkOutput("abort_ld_pc", s3_pc, 32'h608);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
